// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//   - Register offsets within the 16-byte window (word index = address[3:2])
//   - Bit positions of the STATUS register fields
//   - Serialiser FSM state encoding
package uart_mmio_pkg;

   localparam logic [1:0] OFF_TXDATA = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_DIV    = 2'd2;
   localparam logic [1:0] OFF_RSVD   = 2'd3;

   localparam int ST_FULL      = 0;
   localparam int ST_EMPTY     = 1;
   localparam int ST_BUSY      = 2;
   localparam int ST_OVERFLOW  = 3;
   localparam int ST_COUNT_LSB = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/tx_fifo.sv
// Circular byte FIFO feeding the UART serialiser.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (empties the FIFO)
//   push, wdata   write request and data; accepted when not full or when a pop
//                 happens in the same cycle
//   pop, rdata    read request; rdata shows the head entry combinationally
//   full, empty   occupancy flags
//   count         number of stored entries (0..DEPTH)
//   drop          push refused this cycle (FIFO full and no simultaneous pop)
module tx_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     drop
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign pop_ok  = pop && !empty;
   // A pop in the same cycle frees the slot the push lands in.
   assign push_ok = push && (!full || pop_ok);
   assign drop    = push && !push_ok;
   assign rdata   = mem[rd_ptr];

   // NOTE: storage array has no reset; count/pointers define validity, and a
   // resettable array would cost a reset net on every bit for no benefit.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART 8N1 transmitter on the MEM-stage data bus.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   w_en[3:0]    byte-lane write enables (SRAM encoding)
//   address      byte address; window hit when address[15:4]==BASE_ADDR[15:4]
//   write_data   store data, lane 0 = bits [7:0]
//   hit          combinational window decode
//   read_data    combinational register read, 0 when !hit
//   tx           registered serial output, idle high
//   irq          FIFO empty and serialiser idle
// Registers (word offset): 0 TXDATA (W push), 1 STATUS (R, W bit3 clears
// overflow), 2 DIV (R/W baud divisor, bit = DIV+1 clocks), 3 reserved.
module mmio_uart_tx
   import uart_mmio_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR   = 16'hF000,
   parameter int          FIFO_DEPTH  = 16,
   parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  w_en,
   input  logic [15:0] address,
   input  logic [31:0] write_data,
   output logic        hit,
   output logic [31:0] read_data,
   output logic        tx,
   output logic        irq
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   // Bus decode
   logic [1:0] offset;
   logic       push;
   logic       ovf_clr;
   logic       div_wr_lo;
   logic       div_wr_hi;

   // Register file
   logic [15:0] div;
   logic        overflow;

   // FIFO interface
   logic          pop;
   logic [7:0]    fifo_rdata;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic          fifo_drop;

   // Serialiser state
   tx_state_t   state, state_d;
   logic [15:0] baud_cnt, baud_d;
   logic [2:0]  bit_idx, bit_d;
   logic [7:0]  shift, shift_d;
   logic        tx_d;
   logic        bit_done;
   logic        busy;

   logic [31:0] status_word;
   logic        unused_bus_bits;

   // Byte-offset bits, upper store lanes and w_en[3:2] have no target here.
   assign unused_bus_bits = ^{address[1:0], write_data[31:16], w_en[3:2]};

   assign hit       = (address[15:4] == BASE_ADDR[15:4]);
   assign offset    = address[3:2];
   assign push      = hit && (offset == OFF_TXDATA) && w_en[0];
   assign ovf_clr   = hit && (offset == OFF_STATUS) && w_en[0] && write_data[ST_OVERFLOW];
   assign div_wr_lo = hit && (offset == OFF_DIV) && w_en[0];
   assign div_wr_hi = hit && (offset == OFF_DIV) && w_en[1];

   assign busy = (state != IDLE);
   assign irq  = fifo_empty && !busy;

   assign status_word = {16'b0, 8'(fifo_count), 4'b0, overflow, busy, fifo_empty, fifo_full};

   always_comb begin
      read_data = '0;
      if (hit) begin
         case (offset)
            OFF_STATUS: read_data = status_word;
            OFF_DIV:    read_data = {16'b0, div};
            default:    read_data = '0;
         endcase
      end
   end

   tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (write_data[7:0]),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count),
      .drop  (fifo_drop)
   );

   // Overflow is sticky; a software clear loses to a push that overflows in
   // the same cycle, so a freshly dropped byte is never hidden.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div      <= DEFAULT_DIV;
         overflow <= 1'b0;
      end else begin
         if (div_wr_lo) div[7:0]  <= write_data[7:0];
         if (div_wr_hi) div[15:8] <= write_data[15:8];
         if (fifo_drop)    overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

   assign bit_done = (baud_cnt == '0);

   // Serialiser next-state. The baud counter is reloaded from div only when a
   // new bit starts, so divisor writes apply at the next bit boundary.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case leaves a signal unassigned and no latch is inferred.
      state_d = state;
      baud_d  = baud_cnt;
      bit_d   = bit_idx;
      shift_d = shift;
      tx_d    = tx;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = START;
               baud_d  = div;
               shift_d = fifo_rdata;
               tx_d    = 1'b0;
            end
         end
         START: begin
            if (bit_done) begin
               state_d = DATA;
               baud_d  = div;
               bit_d   = 3'd0;
               tx_d    = shift[0];
               shift_d = shift >> 1;
            end else begin
               baud_d = baud_cnt - 1'b1;
            end
         end
         DATA: begin
            if (bit_done) begin
               baud_d = div;
               if (bit_idx == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d   = bit_idx + 1'b1;
                  tx_d    = shift[0];
                  shift_d = shift >> 1;
               end
            end else begin
               baud_d = baud_cnt - 1'b1;
            end
         end
         STOP: begin
            if (bit_done) begin
               if (!fifo_empty) begin
                  // Back-to-back frame: next start bit follows with no gap.
                  pop     = 1'b1;
                  state_d = START;
                  baud_d  = div;
                  shift_d = fifo_rdata;
                  tx_d    = 1'b0;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end
            end else begin
               baud_d = baud_cnt - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values computed above, independent of block order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
      end else begin
         state    <= state_d;
         baud_cnt <= baud_d;
         bit_idx  <= bit_d;
         shift    <= shift_d;
         tx       <= tx_d;
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: directed scenarios plus random frames,
// with expected waveforms and FIFO occupancy computed from the UART rules.
module tb_mmio_uart_tx;

   localparam logic [15:0] A_TX  = 16'hF000;
   localparam logic [15:0] A_ST  = 16'hF004;
   localparam logic [15:0] A_DIV = 16'hF008;
   localparam logic [15:0] A_RSV = 16'hF00C;
   localparam int          DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  w_en;
   logic [15:0] address;
   logic [31:0] write_data;
   logic        hit;
   logic [31:0] read_data;
   logic        tx;
   logic        irq;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int cyc      = 0;

   mmio_uart_tx dut (
      .clk        (clk),
      .rst        (rst),
      .w_en       (w_en),
      .address    (address),
      .write_data (write_data),
      .hit        (hit),
      .read_data  (read_data),
      .tx         (tx),
      .irq        (irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [3:0] we, input logic [31:0] d);
      @(negedge clk);
      address = a; w_en = we; write_data = d;
      @(negedge clk);
      w_en = 4'b0;
   endtask

   task automatic rd(input logic [15:0] a, output logic [31:0] d);
      @(negedge clk);
      address = a; w_en = 4'b0;
      #1 d = read_data;
   endtask

   // Line level of a frame at bit slot n: start, 8 data LSB first, stop.
   function automatic logic frame_bit(input logic [7:0] b, input int n);
      if (n == 0) return 1'b0;
      if (n == 9) return 1'b1;
      return b[n-1];
   endfunction

   function automatic logic [31:0] status_of(input int cnt, input logic ovf, input logic bsy);
      return {16'b0, 8'(cnt), 4'b0, ovf, bsy, (cnt == 0), (cnt == DEPTH)};
   endfunction

   // Program DIV, push one byte into an idle UART and compare every cycle of
   // the resulting frame against the ideal 8N1 waveform.
   task automatic send_check(input logic [7:0] b, input int d);
      int bad;
      int busy_bad;
      bad = 0; busy_bad = 0;
      wr(A_DIV, 4'b0011, 32'(d));
      wr(A_TX, 4'b0001, {24'b0, b});
      address = A_ST;
      for (int k = 0; k < 10 * (d + 1); k++) begin
         @(negedge clk);
         if (tx !== frame_bit(b, k / (d + 1))) bad++;
         if (read_data[2] !== 1'b1) busy_bad++;
      end
      check($sformatf("frame_%02h_div%0d_wave", b, d), 32'(bad), 0);
      check($sformatf("frame_%02h_div%0d_busy", b, d), 32'(busy_bad), 0);
      @(negedge clk);
      check($sformatf("frame_%02h_div%0d_irq", b, d), {30'b0, irq, tx}, 32'h3);
   endtask

   initial begin
      logic [31:0] r;
      int first_edge, t_pop, cnt, drops, bad;
      logic started, pop_now, acc;

      rst = 1'b1; w_en = 4'b0; address = 16'h0000; write_data = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      #1;
      check("reset_tx_irq", {30'b0, tx, irq}, 32'h3);
      rd(A_ST, r);  check("reset_status", r, 32'h0000_0002);
      rd(A_DIV, r); check("reset_div", r, 32'd433);
      check("hit_window", {31'b0, hit}, 32'h1);
      rd(A_TX, r);  check("txdata_reads_zero", r, 32'h0);
      rd(A_RSV, r); check("rsvd_reads_zero", r, 32'h0);

      // Directed frame: 8'hA5 at DIV=3
      send_check(8'hA5, 3);

      // Lane-0 only DIV write keeps the upper byte
      wr(A_DIV, 4'b0001, 32'h0000_1234);
      rd(A_DIV, r); check("div_lane0", r, 32'h0000_0034);
      @(negedge clk);
      address = 16'h1000; w_en = 4'hF; write_data = 32'hFFFF_FFFF;
      #1;
      check("miss_hit", {31'b0, hit}, 32'h0);
      check("miss_read_zero", read_data, 32'h0);
      @(negedge clk); w_en = 4'b0;
      rd(A_DIV, r); check("miss_div_unchanged", r, 32'h0000_0034);
      rd(A_ST, r);  check("miss_status_unchanged", r, 32'h0000_0002);

      // Random frames
      for (int i = 0; i < 6; i++)
         send_check(8'($urandom_range(0, 255)), $urandom_range(0, 4));

      // Overflow: long bits so only the first frame's pop happens during a
      // burst of 18 consecutive pushes.
      wr(A_DIV, 4'b0011, 32'd50);
      @(negedge clk);
      first_edge = cyc + 1;
      cnt = 0; drops = 0; started = 1'b0;
      for (int i = 0; i < 18; i++) begin
         address = A_TX; w_en = 4'b0001; write_data = 32'(i);
         pop_now = (i >= 1) && !started && (cnt > 0);
         if (pop_now) started = 1'b1;
         acc = (cnt < DEPTH) || pop_now;
         if (!acc) drops++;
         cnt = cnt + int'(acc) - int'(pop_now);
         @(negedge clk);
      end
      w_en = 4'b0;
      check("overflow_drops_one", 32'(drops), 32'd1);
      rd(A_ST, r); check("overflow_status", r, status_of(cnt, drops > 0, 1'b1));
      wr(A_ST, 4'b0001, 32'h0000_0008);
      rd(A_ST, r); check("overflow_cleared", r, status_of(cnt, 1'b0, 1'b1));

      // Push while full on the edge where STOP hands over to the next START
      t_pop = first_edge + 1 + 10 * 51;
      while (cyc < t_pop - 1) @(negedge clk);
      check("stop_bit_before_pop", {31'b0, tx}, 32'h1);
      address = A_TX; w_en = 4'b0001; write_data = 32'h0000_00EE;
      @(negedge clk);
      w_en = 4'b0; address = A_ST;
      #1;
      check("b2b_start_bit", {31'b0, tx}, 32'h0);
      check("full_push_on_pop", read_data, status_of(DEPTH, 1'b0, 1'b1));

      // Reset during data bit 3 of the frame carrying byte 8'h01
      while (cyc < t_pop + 51 * 4 + 20) @(negedge clk);
      check("data_bit3_level", {31'b0, tx}, {31'b0, frame_bit(8'h01, 4)});
      #2 rst = 1'b1;
      #1;
      check("rst_tx_immediate", {31'b0, tx}, 32'h1);
      check("rst_status_immediate", read_data, 32'h0000_0002);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bad = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (tx !== 1'b1 || irq !== 1'b1 || read_data !== 32'h0000_0002) bad++;
      end
      check("post_rst_quiet", 32'(bad), 32'h0);
      rd(A_DIV, r); check("post_rst_div", r, 32'd433);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
